// File: rtl/rb_read_ctrl_pkg.sv
// rb_read_ctrl_pkg: shared sizes and FSM encoding for the packed-pixel BRAM read controller
package rb_read_ctrl_pkg;
   localparam int PIXEL_WIDTH       = 8;
   localparam int RBS               = 4;
   localparam int BRAM_DEPTH        = 256;
   localparam int RB_READ_DEPTH     = BRAM_DEPTH / RBS;
   localparam int BRAM_R_ADDR_WIDTH = $clog2(RB_READ_DEPTH);
   localparam int BRAM_R_DATA_WIDTH = RBS * PIXEL_WIDTH;

   typedef enum logic [1:0] {
      RBR_IDLE  = 2'd0,
      RBR_RUN   = 2'd1,
      RBR_DRAIN = 2'd2
   } rbr_state_e;
endpackage

// File: rtl/rb_read_ctrl_skid.sv
// rb_skid_buffer: 2-entry (data, last) FIFO whose occupancy feeds the read-issue credit check
module rb_skid_buffer
   import rb_read_ctrl_pkg::*;
#(
   parameter int DW = BRAM_R_DATA_WIDTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic [1:0]    count
);
   logic [DW:0] e0_q, e0_d, e1_q, e1_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        pop;

   assign pop       = out_valid & out_ready;
   assign out_valid = cnt_q != 2'd0;
   assign out_data  = e0_q[DW-1:0];
   assign out_last  = out_valid & e0_q[DW];
   assign count     = cnt_q;

   // Entry 0 is always the head; a push lands in the first slot free after this cycle's pop.
   always_comb begin
      e0_d  = pop ? e1_q : e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q - {1'b0, pop};
      if (in_valid) begin
         if (cnt_d == 2'd0) e0_d = {in_last, in_data};
         else e1_d = {in_last, in_data};
         cnt_d = cnt_d + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= 2'd0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/rb_read_ctrl.sv
// rb_read_ctrl: burst reader from BRAM port B into a valid/ready stream with full backpressure.
// Define RB_READ_WRAP_EN to let bursts wrap from the last word back to address 0.
module rb_read_ctrl
   import rb_read_ctrl_pkg::*;
#(
   parameter int AW     = BRAM_R_ADDR_WIDTH,
   parameter int DW     = BRAM_R_DATA_WIDTH,
   parameter int RDEPTH = RB_READ_DEPTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   len,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          bram_en_b,
   output logic [AW-1:0] bram_addr_b,
   input  logic [DW-1:0] bram_dout_b,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          m_last
);
   rbr_state_e    state_q, state_d;
   logic [AW-1:0] addr_q, addr_d, addr_nx;
   logic [AW:0]   issue_q, issue_d, out_q, out_d;
   logic          rd_q, rd_d, rd_last_q, rd_last_d, zdone_q, zdone_d, err_q, err_d;
   logic [1:0]    occ;
   logic          pop, req_bad;

   assign pop = m_valid & m_ready;

`ifdef RB_READ_WRAP_EN
   assign req_bad = len > (AW+1)'(RDEPTH);
   assign addr_nx = (addr_q == AW'(RDEPTH - 1)) ? '0 : addr_q + AW'(1);
`else
   assign req_bad = ((AW+2)'(base_addr) + (AW+2)'(len)) > (AW+2)'(RDEPTH);
   assign addr_nx = addr_q + AW'(1);
`endif

   // Credit counts the head word leaving this cycle as already gone, which is what sustains 1 word/cycle.
   assign bram_en_b   = (state_q == RBR_RUN) && (issue_q != '0) &&
                        ((3'(occ) + 3'(rd_q) - 3'(pop)) < 3'd2);
   assign bram_addr_b = addr_q;
   assign busy        = state_q != RBR_IDLE;
   assign done        = zdone_q | ((state_q == RBR_DRAIN) && (out_q == '0));
   assign err         = err_q;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      issue_d   = issue_q;
      out_d     = out_q;
      zdone_d   = 1'b0;
      err_d     = 1'b0;
      rd_d      = bram_en_b;
      rd_last_d = bram_en_b && (issue_q == (AW+1)'(1));
      case (state_q)
         RBR_IDLE: begin
            if (start) begin
               if (len == '0) zdone_d = 1'b1;
               else if (req_bad) err_d = 1'b1;
               else begin
                  state_d = RBR_RUN;
                  addr_d  = base_addr;
                  issue_d = len;
                  out_d   = len;
               end
            end
         end
         RBR_RUN: begin
            if (bram_en_b) begin
               addr_d  = addr_nx;
               issue_d = issue_q - (AW+1)'(1);
               if (issue_q == (AW+1)'(1)) state_d = RBR_DRAIN;
            end
         end
         RBR_DRAIN: if (out_q == '0) state_d = RBR_IDLE;
         default: state_d = RBR_IDLE;
      endcase
      if (pop) out_d = out_q - (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RBR_IDLE;
         addr_q    <= '0;
         issue_q   <= '0;
         out_q     <= '0;
         rd_q      <= 1'b0;
         rd_last_q <= 1'b0;
         zdone_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         issue_q   <= issue_d;
         out_q     <= out_d;
         rd_q      <= rd_d;
         rd_last_q <= rd_last_d;
         zdone_q   <= zdone_d;
         err_q     <= err_d;
      end
   end

   rb_skid_buffer #(.DW(DW)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rd_q),
      .in_data   (bram_dout_b),
      .in_last   (rd_last_q),
      .out_valid (m_valid),
      .out_ready (m_ready),
      .out_data  (m_data),
      .out_last  (m_last),
      .count     (occ)
   );
endmodule

// File: tb/tb_rb_read_ctrl.sv
// tb_rb_read_ctrl: directed bursts against a 1-cycle-latency BRAM model with a stream monitor.
module tb_rb_read_ctrl;
   import rb_read_ctrl_pkg::*;
   localparam int AW = BRAM_R_ADDR_WIDTH;
   localparam int DW = BRAM_R_DATA_WIDTH;
   localparam int RD = RB_READ_DEPTH;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, m_ready = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   len = '0;
   logic          busy, done, err, bram_en_b, m_valid, m_last;
   logic [AW-1:0] bram_addr_b;
   logic [DW-1:0] bram_dout_b = '0;
   logic [DW-1:0] m_data;
   logic [DW-1:0] mem [RD];

   int checks = 0, errors = 0;
   int cyc = 0, outst = 0, n_wait = 0;
   int done_cnt, err_cnt, busy_cnt, credit_viol, stall_viol, stall_seen;
   int start_cyc, first_vld, done_cyc, last_xfer;
   logic          stall_p = 1'b0, stall_l = 1'b0;
   logic [DW-1:0] stall_d = '0;
   logic [DW-1:0] got_data[$];
   logic          got_last[$];
   int            got_addr[$];
   int            en_cyc[$];

   always #5 clk = ~clk;

   rb_read_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .base_addr   (base_addr),
      .len         (len),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .bram_en_b   (bram_en_b),
      .bram_addr_b (bram_addr_b),
      .bram_dout_b (bram_dout_b),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_last      (m_last)
   );

   // Pixel p holds (7p+3) mod 256; word w packs pixels 4w..4w+3, lowest pixel in the low byte.
   function automatic logic [DW-1:0] word(input int w);
      logic [DW-1:0] r = '0;
      for (int k = 0; k < RBS; k++) r[k*PIXEL_WIDTH +: PIXEL_WIDTH] = PIXEL_WIDTH'((w*RBS + k)*7 + 3);
      return r;
   endfunction

   initial for (int w = 0; w < RD; w++) mem[w] = word(w);

   always @(posedge clk) bram_dout_b <= bram_en_b ? mem[bram_addr_b] : '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear();
      got_data.delete(); got_last.delete(); got_addr.delete(); en_cyc.delete();
      done_cnt = 0; err_cnt = 0; busy_cnt = 0; credit_viol = 0; stall_viol = 0; stall_seen = 0;
      start_cyc = -1; first_vld = -1; done_cyc = -1; last_xfer = -1;
   endtask

   initial forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         outst = 0;
         stall_p = 1'b0;
      end else begin
         if (stall_p && !(m_valid && m_data == stall_d && m_last == stall_l)) stall_viol++;
         if (start && start_cyc < 0) start_cyc = cyc;
         if (m_valid && first_vld < 0) first_vld = cyc;
         if (bram_en_b) begin
            if (outst - int'(m_valid && m_ready) >= 2) credit_viol++;
            got_addr.push_back(int'(bram_addr_b));
            en_cyc.push_back(cyc);
            outst++;
         end
         if (m_valid && m_ready) begin
            got_data.push_back(m_data);
            got_last.push_back(m_last);
            last_xfer = cyc;
            outst--;
         end
         if (m_valid && !m_ready) stall_seen++;
         stall_p = m_valid && !m_ready;
         stall_d = m_data;
         stall_l = m_last;
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (err) err_cnt++;
         if (busy) busy_cnt++;
      end
   end

   task automatic burst(input int base, input int n, input bit toggle, input bit poke);
      int c = 0;
      clear();
      base_addr = AW'(base);
      len       = (AW+1)'(n);
      start     = 1'b1;
      m_ready   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (done_cnt == 0 && err_cnt == 0 && c < 200) begin
         if (toggle) m_ready = ~m_ready;
         if (poke && c == 3) begin
            start = 1'b1; base_addr = '0; len = (AW+1)'(1);
         end else start = 1'b0;
         @(posedge clk); #1;
         c++;
      end
      start   = 1'b0;
      m_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("timeout", c < 200, 1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_ctl", {busy, done, err, bram_en_b, m_valid, m_last}, 0);
      check("rst_addr", bram_addr_b, 0);
      check("rst_data", m_data, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      burst(4, 3, 1'b0, 1'b0);
      check("b1_n", got_data.size(), 3);
      for (int i = 0; i < 3; i++) check("b1_addr", got_addr[i], 4 + i);
      check("b1_en_span", en_cyc[2] - en_cyc[0], 2);
      check("b1_w0", got_data[0], 32'h8881_7A73);
      check("b1_w1", got_data[1], word(5));
      check("b1_w2", got_data[2], word(6));
      check("b1_last", {got_last[0], got_last[1], got_last[2]}, 3'b001);
      check("b1_lat", first_vld - start_cyc, 3);
      check("b1_done_at", done_cyc - last_xfer, 1);
      check("b1_done_n", done_cnt, 1);
      check("b1_busy", busy_cnt, 6);

      burst(10, 8, 1'b1, 1'b0);
      check("bp_n", got_data.size(), 8);
      for (int i = 0; i < 8; i++) begin
         check("bp_addr", got_addr[i], 10 + i);
         check("bp_data", got_data[i], word(10 + i));
         check("bp_last", got_last[i], i == 7);
      end
      check("bp_credit", credit_viol, 0);
      check("bp_stable", stall_viol, 0);
      check("bp_stalls", stall_seen > 0, 1);
      check("bp_done_n", done_cnt, 1);

      burst(7, 0, 1'b0, 1'b0);
      check("z_done_n", done_cnt, 1);
      check("z_done_at", done_cyc - start_cyc, 1);
      check("z_en", got_addr.size(), 0);
      check("z_busy", busy_cnt, 0);
      check("z_err", err_cnt, 0);

      burst(RD - 2, 4, 1'b0, 1'b0);
`ifdef RB_READ_WRAP_EN
      check("wr_n", got_data.size(), 4);
      check("wr_err", err_cnt, 0);
      for (int i = 0; i < 4; i++) begin
         check("wr_addr", got_addr[i], (RD - 2 + i) % RD);
         check("wr_data", got_data[i], word((RD - 2 + i) % RD));
      end
      burst(0, RD + 1, 1'b0, 1'b0);
      check("wr_big_err", err_cnt, 1);
      check("wr_big_en", got_addr.size(), 0);
`else
      check("bd_err", err_cnt, 1);
      check("bd_en", got_addr.size(), 0);
      check("bd_done", done_cnt, 0);
      check("bd_busy", busy_cnt, 0);
      burst(RD - 4, 4, 1'b0, 1'b0);
      check("fit_err", err_cnt, 0);
      check("fit_n", got_data.size(), 4);
      check("fit_a3", got_addr[3], RD - 1);
      check("fit_d3", got_data[3], word(RD - 1));
`endif

      burst(20, 5, 1'b0, 1'b1);
      check("sb_err", err_cnt, 0);
      check("sb_n", got_data.size(), 5);
      check("sb_en_n", got_addr.size(), 5);
      for (int i = 0; i < 5; i++) check("sb_data", got_data[i], word(20 + i));
      check("sb_done_n", done_cnt, 1);

      clear();
      base_addr = AW'(30); len = (AW+1)'(8); start = 1'b1; m_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_wait = 0;
      while (got_data.size() < 2 && n_wait < 50) begin
         @(posedge clk); #1;
         n_wait++;
      end
      check("ar_reach", n_wait < 50, 1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_ctl", {busy, done, err, bram_en_b, m_valid, m_last}, 0);
      check("ar_addr", bram_addr_b, 0);
      check("ar_data", m_data, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      burst(4, 3, 1'b0, 1'b0);
      check("ar_n", got_data.size(), 3);
      check("ar_w0", got_data[0], 32'h8881_7A73);
      check("ar_w2", got_data[2], word(6));
      check("ar_done_n", done_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
